// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Package: pipe_ctrl_pkg
// Shared types and constants for the pipeline hazard controller.
//   wait_state_e : data-memory wait sequencer state
//   REG_ADDR_W   : register-file address width
//   ZERO_REG     : hard-wired zero register address
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } wait_state_e;

    localparam int          REG_ADDR_W = 5;
    localparam logic [4:0]  ZERO_REG   = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_dmem_wait_fsm.sv
// Module: dmem_wait_fsm
// Tracks multi-cycle data-memory accesses and freezes the pipeline until the
// memory acknowledges or the wait exceeds TIMEOUT cycles.
//   clk_i, rst_i    : clock, synchronous active-high reset
//   dmem_req_i      : MEM stage issues an access
//   dmem_ack_i      : memory completes the access (1-cycle pulse)
//   freeze_o        : hold every pipeline register and PC (combinational)
//   timeout_err_o   : sticky, an access exceeded TIMEOUT cycles
//
// state    | meaning
// RUN      | no access outstanding; a req without same-cycle ack freezes
// MEM_WAIT | access outstanding; freeze until ack or TIMEOUT reached
module dmem_wait_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic dmem_req_i,
    input  logic dmem_ack_i,
    output logic freeze_o,
    output logic timeout_err_o
);

    localparam logic [TO_W-1:0] TIMEOUT_C = TO_W'(TIMEOUT);

    wait_state_e     state_q, state_d;
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            err_q, err_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        freeze_o   = 1'b0;
        case (state_q)
            RUN: begin
                if (dmem_req_i && !dmem_ack_i) begin
                    freeze_o   = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = TO_W'(1);
                end
            end
            MEM_WAIT: begin
                if (dmem_ack_i) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == TIMEOUT_C) begin
                    // Access is dropped: release the pipeline and flag it.
                    state_d    = RUN;
                    wait_cnt_d = '0;
                    err_d      = 1'b1;
                end else begin
                    freeze_o   = 1'b1;
                    wait_cnt_d = wait_cnt_q + TO_W'(1);
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
        if (rst_i) begin
            freeze_o = 1'b0;
        end
    end

    assign timeout_err_o = err_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Module: pipeline_hazard_ctrl
// Central stall/flush sequencer for the 5-stage pipeline.
//   clk_i, rst_i                  : clock, synchronous active-high reset
//   ID_rs_i, ID_rt_i, ID_uses_rt_i: source operands of the ID instruction
//   EX_MemRead_i, EX_rt_i         : load in EX and its destination
//   branch_taken_i                : branch/jump in ID resolved taken
//   dmem_req_i, dmem_ack_i        : data-memory handshake from MEM
//   PC_write_o, IF_ID_stall_o, IF_ID_flush_o, ID_EX_bubble_o, freeze_o
//                                 : pipeline control (combinational)
//   stall_cnt_o                   : saturating count of cycles with PC_write_o==0
//   timeout_err_o                 : sticky memory-timeout error
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [REG_ADDR_W-1:0] ID_rs_i,
    input  logic [REG_ADDR_W-1:0] ID_rt_i,
    input  logic                  ID_uses_rt_i,
    input  logic                  EX_MemRead_i,
    input  logic [REG_ADDR_W-1:0] EX_rt_i,
    input  logic                  branch_taken_i,
    input  logic                  dmem_req_i,
    input  logic                  dmem_ack_i,
    output logic                  PC_write_o,
    output logic                  IF_ID_stall_o,
    output logic                  IF_ID_flush_o,
    output logic                  ID_EX_bubble_o,
    output logic                  freeze_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic                  timeout_err_o
);

    logic             freeze;
    logic             load_use;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    dmem_wait_fsm #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_dmem_wait_fsm (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .dmem_req_i    (dmem_req_i),
        .dmem_ack_i    (dmem_ack_i),
        .freeze_o      (freeze),
        .timeout_err_o (timeout_err_o)
    );

    // A load into r0 never creates a real dependency.
    assign load_use = EX_MemRead_i && (EX_rt_i != ZERO_REG) &&
                      ((EX_rt_i == ID_rs_i) || (ID_uses_rt_i && (EX_rt_i == ID_rt_i)));

    always_comb begin
        PC_write_o     = 1'b1;
        IF_ID_stall_o  = 1'b0;
        IF_ID_flush_o  = 1'b0;
        ID_EX_bubble_o = 1'b0;
        if (rst_i) begin
            PC_write_o     = 1'b0;
            IF_ID_flush_o  = 1'b1;
            ID_EX_bubble_o = 1'b1;
        end else if (freeze) begin
            PC_write_o    = 1'b0;
            IF_ID_stall_o = 1'b1;
        end else if (load_use) begin
            // Branch resolution waits one cycle for the forwarded load data.
            PC_write_o     = 1'b0;
            IF_ID_stall_o  = 1'b1;
            ID_EX_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
            IF_ID_flush_o = 1'b1;
        end
    end

    assign freeze_o = freeze;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!PC_write_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int TO      = 4;
    localparam int MAX_A   = 65535;
    localparam int MAX_S   = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       uses_rt, memrd, br, req, ack;

    logic        pcw, stl, fls, bub, frz, err;
    logic [15:0] scnt;
    logic        pcw_s, stl_s, fls_s, bub_s, frz_s, err_s;
    logic [1:0]  scnt_s;

    int checks   = 0;
    int failures = 0;

    // model state
    bit m_valid = 1'b0;
    bit m_pending = 1'b0;
    int m_waited = 0;
    bit m_err = 1'b0;
    int m_stalls = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(16), .TIMEOUT(TO), .TO_W(3)) dut (
        .clk_i(clk), .rst_i(rst), .ID_rs_i(id_rs), .ID_rt_i(id_rt),
        .ID_uses_rt_i(uses_rt), .EX_MemRead_i(memrd), .EX_rt_i(ex_rt),
        .branch_taken_i(br), .dmem_req_i(req), .dmem_ack_i(ack),
        .PC_write_o(pcw), .IF_ID_stall_o(stl), .IF_ID_flush_o(fls),
        .ID_EX_bubble_o(bub), .freeze_o(frz), .stall_cnt_o(scnt),
        .timeout_err_o(err));

    pipeline_hazard_ctrl #(.CNT_W(2), .TIMEOUT(TO), .TO_W(3)) dut_s (
        .clk_i(clk), .rst_i(rst), .ID_rs_i(id_rs), .ID_rt_i(id_rt),
        .ID_uses_rt_i(uses_rt), .EX_MemRead_i(memrd), .EX_rt_i(ex_rt),
        .branch_taken_i(br), .dmem_req_i(req), .dmem_ack_i(ack),
        .PC_write_o(pcw_s), .IF_ID_stall_o(stl_s), .IF_ID_flush_o(fls_s),
        .ID_EX_bubble_o(bub_s), .freeze_o(frz_s), .stall_cnt_o(scnt_s),
        .timeout_err_o(err_s));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected control outputs from the rules: reset, then freeze, load-use, branch.
    function automatic void model_outs(output bit e_pcw, output bit e_stl, output bit e_fls,
                                       output bit e_bub, output bit e_frz);
        bit lu;
        e_pcw = 1; e_stl = 0; e_fls = 0; e_bub = 0; e_frz = 0;
        if (rst) begin
            e_pcw = 0; e_fls = 1; e_bub = 1;
            return;
        end
        if (m_pending) e_frz = !ack && (m_waited < TO);
        else           e_frz = req && !ack;
        lu = memrd && (ex_rt != 0) && ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
        if (e_frz) begin
            e_pcw = 0; e_stl = 1;
        end else if (lu) begin
            e_pcw = 0; e_stl = 1; e_bub = 1;
        end else if (br) begin
            e_fls = 1;
        end
    endfunction

    always @(posedge clk) begin
        bit e_pcw, e_stl, e_fls, e_bub, e_frz;
        model_outs(e_pcw, e_stl, e_fls, e_bub, e_frz);
        if (rst) begin
            m_valid = 1; m_pending = 0; m_waited = 0; m_err = 0; m_stalls = 0;
        end else begin
            if (!e_pcw) m_stalls++;
            if (m_pending) begin
                if (ack) begin
                    m_pending = 0;
                end else if (m_waited >= TO) begin
                    m_pending = 0; m_err = 1;
                end else begin
                    m_waited++;
                end
            end else if (req && !ack) begin
                m_pending = 1; m_waited = 1;
            end
        end
    end

    always @(negedge clk) begin
        bit e_pcw, e_stl, e_fls, e_bub, e_frz;
        model_outs(e_pcw, e_stl, e_fls, e_bub, e_frz);
        chk("pc_write", int'(pcw), int'(e_pcw));
        chk("if_id_stall", int'(stl), int'(e_stl));
        chk("if_id_flush", int'(fls), int'(e_fls));
        chk("id_ex_bubble", int'(bub), int'(e_bub));
        chk("freeze", int'(frz), int'(e_frz));
        chk("s_ctrl", int'({pcw_s, stl_s, fls_s, bub_s, frz_s}),
            int'({e_pcw, e_stl, e_fls, e_bub, e_frz}));
        if (!rst && stl && fls) chk("stall_flush_excl", 1, 0);
        if (m_valid) begin
            chk("stall_cnt", int'(scnt), (m_stalls > MAX_A) ? MAX_A : m_stalls);
            chk("stall_cnt_sat", int'(scnt_s), (m_stalls > MAX_S) ? MAX_S : m_stalls);
            chk("timeout_err", int'(err), int'(m_err));
            chk("timeout_err_s", int'(err_s), int'(m_err));
        end
    end

    task automatic set_in(input bit r, input logic [4:0] rs, input logic [4:0] rt, input bit ur,
                          input bit mr, input logic [4:0] er, input bit b, input bit q, input bit a);
        rst = r; id_rs = rs; id_rt = rt; uses_rt = ur; memrd = mr; ex_rt = er;
        br = b; req = q; ack = a;
    endtask

    task automatic idle();
        set_in(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0);
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_in(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
        to_neg();
        chk("rst_pcw", int'(pcw), 0);
        chk("rst_flush", int'(fls), 1);
        chk("rst_bubble", int'(bub), 1);
        chk("rst_freeze", int'(frz), 0);
        next_cyc();

        // 1: load-use on rs
        set_in(0, 5'd5, 5'd9, 0, 1, 5'd5, 0, 0, 0);
        to_neg();
        chk("t1_pcw", int'(pcw), 0);
        chk("t1_stall", int'(stl), 1);
        chk("t1_bubble", int'(bub), 1);
        chk("t1_cnt0", int'(scnt), 0);
        next_cyc();
        idle();
        to_neg();
        chk("t1_cnt1", int'(scnt), 1);
        chk("t1_pcw_after", int'(pcw), 1);
        next_cyc();

        // 2: r0 load, rt match without rt use, then with rt use
        set_in(0, 5'd0, 5'd4, 0, 1, 5'd0, 0, 0, 0);
        to_neg();
        chk("t2_r0_pcw", int'(pcw), 1);
        next_cyc();
        set_in(0, 5'd3, 5'd7, 0, 1, 5'd7, 0, 0, 0);
        to_neg();
        chk("t2_nort_pcw", int'(pcw), 1);
        next_cyc();
        set_in(0, 5'd3, 5'd7, 1, 1, 5'd7, 0, 0, 0);
        to_neg();
        chk("t2_rt_bubble", int'(bub), 1);
        next_cyc();

        // 3: branch alone, then branch with load-use
        set_in(0, 5'd1, 5'd2, 0, 0, 5'd0, 1, 0, 0);
        to_neg();
        chk("t3_flush", int'(fls), 1);
        chk("t3_pcw", int'(pcw), 1);
        chk("t3_cnt2", int'(scnt), 2);
        next_cyc();
        set_in(0, 5'd5, 5'd2, 0, 1, 5'd5, 1, 0, 0);
        to_neg();
        chk("t3_lu_flush", int'(fls), 0);
        chk("t3_lu_stall", int'(stl), 1);
        next_cyc();
        idle();
        to_neg();
        chk("t3_cnt3", int'(scnt), 3);
        next_cyc();

        // 4: req t0, ack t3
        set_in(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
        next_cyc();
        set_in(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0);
        to_neg();
        chk("t4_frz_t0", int'(frz), 1);
        chk("t4_pcw_t0", int'(pcw), 0);
        next_cyc();
        set_in(0, 5'd5, 5'd2, 0, 1, 5'd5, 1, 1, 0);
        to_neg();
        chk("t4_frz_t1", int'(frz), 1);
        chk("t4_bub_t1", int'(bub), 0);
        chk("t4_fls_t1", int'(fls), 0);
        next_cyc();
        set_in(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0);
        to_neg();
        chk("t4_frz_t2", int'(frz), 1);
        next_cyc();
        set_in(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 1);
        to_neg();
        chk("t4_frz_t3", int'(frz), 0);
        chk("t4_pcw_t3", int'(pcw), 1);
        next_cyc();
        idle();
        to_neg();
        chk("t4_cnt3", int'(scnt), 3);
        next_cyc();
        set_in(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 1);
        to_neg();
        chk("t4_reqack_frz", int'(frz), 0);
        next_cyc();
        idle();
        to_neg();
        chk("t4_cnt3_hold", int'(scnt), 3);
        next_cyc();

        // 5: timeout
        for (int i = 0; i < TO; i++) begin
            set_in(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0);
            to_neg();
            chk("t5_frz", int'(frz), 1);
            next_cyc();
        end
        set_in(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0);
        to_neg();
        chk("t5_frz_drop", int'(frz), 0);
        chk("t5_err_pre", int'(err), 0);
        next_cyc();
        idle();
        to_neg();
        chk("t5_err", int'(err), 1);
        chk("t5_frz_run", int'(frz), 0);
        chk("t5_cnt7", int'(scnt), 7);
        chk("t5_sat", int'(scnt_s), 3);
        next_cyc();
        idle();
        to_neg();
        chk("t5_err_sticky", int'(err), 1);
        next_cyc();

        // 6: reset during MEM_WAIT
        set_in(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0);
        to_neg();
        chk("t6_frz_t0", int'(frz), 1);
        next_cyc();
        set_in(1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0);
        to_neg();
        chk("t6_rst_frz", int'(frz), 0);
        chk("t6_rst_flush", int'(fls), 1);
        next_cyc();
        idle();
        to_neg();
        chk("t6_frz_run", int'(frz), 0);
        chk("t6_cnt0", int'(scnt), 0);
        chk("t6_err0", int'(err), 0);
        chk("t6_pcw", int'(pcw), 1);
        next_cyc();
        idle();
        to_neg();
        next_cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
